// File: rtl/seq_ser.sv
// ---------------------------------------------------------------------------
// seq_ser : parallel-in, serial-out feeder for the serial sequence detector.
//
// Accepts WIDTH-bit words over a valid/ready handshake and presents them one
// bit per clock on ser_out. A new word may be accepted on the same cycle the
// last bit of the current word is presented, so consecutive words stream
// without a bubble and detector patterns that straddle a word boundary are
// preserved. A high pause freezes the shifter and marks ser_out as not live.
//
// Optional build macro:
//   SEQ_SER_LSB_FIRST_EN  - when defined, words are emitted LSB-first
//                           (shift right, ser_out = shreg[0]); otherwise
//                           MSB-first. Timing and handshake are identical.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   din        in   [WIDTH] parallel word, sampled only on a transfer edge
//   din_valid  in   din holds a word to transfer
//   din_ready  out  block can accept din this cycle
//   pause      in   freeze shifting while high
//   ser_out    out  current serial bit (detector input)
//   ser_valid  out  ser_out carries a live data bit this cycle
//   busy       out  a word is in progress
//   word_done  out  one-cycle pulse while the last bit of a word is presented
// ---------------------------------------------------------------------------
module seq_ser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             pause,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg_shifted;
  logic             last_bit;
  logic             xfer;

  // The bit on the wire comes straight from the register end that leaves
  // first; the shifted image moves the next bit into that position.
`ifdef SEQ_SER_LSB_FIRST_EN
  assign ser_out       = shreg[0];
  assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
`else
  assign ser_out       = shreg[WIDTH-1];
  assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
`endif

  // The last bit is being consumed this cycle, which frees the register for
  // an immediate reload; this is what makes back-to-back words gapless.
  assign last_bit  = (state == SHIFT) && (cnt == '0) && !pause;
  assign din_ready = (state == IDLE) || last_bit;
  assign xfer      = din_valid && din_ready;

  // Next-state and output decode. Leaving SHIFT without a reload clears the
  // register so ser_out reads 0 while idle.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    ser_valid = 1'b0;
    busy      = 1'b0;
    word_done = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          shreg_nxt = din;
          cnt_nxt   = CNT_LOAD;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        busy      = 1'b1;
        ser_valid = !pause;
        word_done = last_bit;
        if (!pause) begin
          if (cnt != '0) begin
            shreg_nxt = shreg_shifted;
            cnt_nxt   = cnt - CW'(1);
          end else if (xfer) begin
            shreg_nxt = din;
            cnt_nxt   = CNT_LOAD;
          end else begin
            shreg_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        shreg_nxt = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register. Reset abandons any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_seq_ser.sv
// ---------------------------------------------------------------------------
// tb_seq_ser : self-checking bench for seq_ser (WIDTH = 8).
//
// Every word handed to the DUT pushes its expected bit stream (bit value and
// a last-bit flag) onto a scoreboard queue; a negedge monitor pops one entry
// per live serial bit and compares ser_out and word_done. Directed checks in
// the stimulus block cover reset state, handshake, pause and busy timing.
// Honours SEQ_SER_LSB_FIRST_EN for the expected bit order.
// ---------------------------------------------------------------------------
module tb_seq_ser;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             pause;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             word_done;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  seq_ser #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .pause     (pause),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .word_done (word_done)
  );

  // Free-running clock, posedges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Bit k (0-based, in emission order) of a word.
  function automatic logic expBit(input logic [WIDTH-1:0] w, input int k);
`ifdef SEQ_SER_LSB_FIRST_EN
    return w[k];
`else
    return w[WIDTH-1-k];
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive a word and, when it is offered, record the bits it must produce.
  task automatic applyStimulus(input logic [WIDTH-1:0] w, input logic valid);
    exp_t e;
    din       = w;
    din_valid = valid;
    if (valid) begin
      for (int k = 0; k < WIDTH; k++) begin
        e.b    = expBit(w, k);
        e.last = (k == WIDTH - 1);
        expq.push_back(e);
      end
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every live bit must match the next queued bit.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (ser_valid === 1'b1) begin
        checkOutput("bit_expected", 1'(expq.size() != 0), 1'b1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          checkOutput("ser_out", ser_out, e.b);
          checkOutput("word_done", word_done, e.last);
        end
      end else begin
        checkOutput("word_done_quiet", word_done, 1'b0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    pause     = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    checkOutput("rst_ser_out", ser_out, 1'b0);
    checkOutput("rst_ser_valid", ser_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_word_done", word_done, 1'b0);
    checkOutput("rst_din_ready", din_ready, 1'b1);
    mon_en = 1'b1;

    // Single word 8'hA5
    $display("[TB] single word");
    applyStimulus(8'hA5, 1'b1);
    step();
    din_valid = 1'b0;
    #1;
    checkOutput("w1_busy", busy, 1'b1);
    checkOutput("w1_ready_busy", din_ready, 1'b0);
    repeat (7) step();
    #1;
    checkOutput("w1_done_c8", word_done, 1'b1);
    checkOutput("w1_ready_c8", din_ready, 1'b1);
    step();
    #1;
    checkOutput("w1_idle_busy", busy, 1'b0);
    checkOutput("w1_idle_ser", ser_out, 1'b0);
    checkOutput("w1_idle_ready", din_ready, 1'b1);
    checkOutput("w1_idle_valid", ser_valid, 1'b0);

    // Back-to-back words 8'hF0 then 8'h0F, din_valid held
    $display("[TB] back-to-back");
    applyStimulus(8'hF0, 1'b1);
    step();
    applyStimulus(8'h0F, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      #1;
      checkOutput("b2b_valid", ser_valid, 1'b1);
      if (i == 8) checkOutput("b2b_ready_c8", din_ready, 1'b1);
      step();
      if (i == 8) din_valid = 1'b0;
    end
    #1;
    checkOutput("b2b_idle", busy, 1'b0);

    // Busy rejection: 8'hFF offered during 8'hC3, accepted on its last bit
    $display("[TB] busy rejection");
    applyStimulus(8'hC3, 1'b1);
    step();
    applyStimulus(8'hFF, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      #1;
      checkOutput("rej_ready", din_ready, 1'(i == 8));
      step();
    end
    din_valid = 1'b0;
    repeat (8) step();
    #1;
    checkOutput("rej_idle", busy, 1'b0);

    // Pause for 3 cycles starting at bit 3 of 8'hA5
    $display("[TB] pause");
    applyStimulus(8'hA5, 1'b1);
    step();
    din_valid = 1'b0;
    repeat (3) step();
    pause = 1'b1;
    repeat (3) begin
      #1;
      checkOutput("pause_valid", ser_valid, 1'b0);
      checkOutput("pause_ser_hold", ser_out, 1'b0);
      checkOutput("pause_ready", din_ready, 1'b0);
      checkOutput("pause_busy", busy, 1'b1);
      step();
    end
    pause = 1'b0;
    repeat (4) step();
    #1;
    checkOutput("pause_done_c11", word_done, 1'b1);
    step();
    #1;
    checkOutput("pause_idle", busy, 1'b0);

    // Reset during bit 4 of 8'hFF
    $display("[TB] reset mid-word");
    applyStimulus(8'hFF, 1'b1);
    step();
    din_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expq.delete();
    #1;
    checkOutput("mrst_ser_out", ser_out, 1'b0);
    checkOutput("mrst_busy", busy, 1'b0);
    checkOutput("mrst_ready", din_ready, 1'b1);
    checkOutput("mrst_word_done", word_done, 1'b0);
    repeat (10) step();

    // Bit order check with 8'h01
    $display("[TB] bit order");
    applyStimulus(8'h01, 1'b1);
    step();
    din_valid = 1'b0;
    repeat (8) step();
    #1;
    checkOutput("order_idle", busy, 1'b0);

    step();
    checkOutput("queue_drained", 1'(expq.size() == 0), 1'b1);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
